spatial_conv_controller: RTL

//  Sequences one full-frame 3x3 (KERNEL_SIZE) spatial convolution pass.

---
 rtl/spatial_conv_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spatial_conv_controller.sv
// spatial_conv_controller: sequences one full-frame KERNEL_SIZE x KERNEL_SIZE
// convolution pass. Streams read addresses to the input RAM, gates the window
// buffer shift on returning data, and issues output-RAM writes for every
// non-border window.
// Optional feature: define CONV_CTRL_OVF_COUNT_EN to build the saturating
// overflow counter behind ovf_count_o; otherwise the port is tied to zero.
module spatial_conv_controller #(
    parameter int ADDR_WIDTH  = 16,
    parameter int N_ROWS      = 108,
    parameter int N_COLS      = 160,
    parameter int KERNEL_SIZE = 3,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  pause_i,
    input  logic                  overflow_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_en_o,
    output logic                  buf_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  wr_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           ovf_count_o
);

    localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int N_PIX = N_ROWS * N_COLS;
    localparam int N_WR  = (N_ROWS - KERNEL_SIZE + 1) * (N_COLS - KERNEL_SIZE + 1);

    localparam logic [ADDR_WIDTH-1:0] RD_LAST  = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] WR_LAST  = ADDR_WIDTH'(N_WR - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CW-1:0]         COL_LAST = CW'(N_COLS - 1);
    localparam logic [RW-1:0]         ROW_MIN  = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0]         COL_MIN  = CW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rd_en;
    logic                    busy;
    logic                    done;
    logic                    start_acc;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [RD_LATENCY-1:0]   rd_pipe;
    logic                    wr_en_q;
    logic                    buf_en;

    assign start_acc = start_i && ((state == IDLE) || (state == DONE));
    assign buf_en    = rd_pipe[RD_LATENCY-1];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN on the final read, leave DRAIN after the final write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (rd_en && (rd_addr == RD_LAST)) state_nxt = DRAIN;
            DRAIN:   if (wr_en_q && (wr_addr == WR_LAST)) state_nxt = DONE;
            DONE:    if (start_i) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            RUN: begin
                rd_en = !pause_i;
                busy  = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Address counters, read-latency delay line, push position and write strobe
    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            rd_addr <= '0;
            wr_addr <= '0;
            row     <= '0;
            col     <= '0;
            rd_pipe <= '0;
            wr_en_q <= 1'b0;
        end else begin
            rd_pipe[0] <= rd_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            // Addresses stop on their last value so they never leave the frame
            if (rd_en && (rd_addr != RD_LAST)) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (buf_en) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // Window output settles the cycle after the push that completes it
            wr_en_q <= buf_en && (row >= ROW_MIN) && (col >= COL_MIN);
            if (wr_en_q && (wr_addr != WR_LAST)) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    assign rd_en_o   = rd_en;
    assign rd_addr_o = rd_addr;
    assign buf_en_o  = buf_en;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr;
    assign busy_o    = busy;
    assign done_o    = done;

`ifdef CONV_CTRL_OVF_COUNT_EN
    logic [15:0] ovf_count;

    // Saturating count of writes flagged as overflowed, cleared per frame
    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            ovf_count <= '0;
        end else if (wr_en_q && overflow_i && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    assign ovf_count_o = ovf_count;
`else
    logic unused_overflow;

    assign unused_overflow = overflow_i;
    assign ovf_count_o     = '0;
`endif

endmodule
